// File: rtl/wide_add_seq_pkg.sv
// Shared constants for the word-serial multi-precision adder/subtractor.
// State encoding is kept as plain 2-bit constants for legacy-compatible netlists.
package wide_add_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_RUN  = 2'b01;
    localparam state_t ST_DONE = 2'b10;

    // Default slice width and slice count for the ALU build.
    localparam int DEF_W = 4;
    localparam int DEF_K = 4;

endpackage

// File: rtl/wide_add_seq_rca.sv
// N-bit ripple-carry adder, used as the single shared slice adder.
module wide_add_seq_rca #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    always_comb begin : ripple
        logic c;
        s = '0;
        c = ci;
        for (int i = 0; i < N; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/wide_add_seq.sv
// Word-serial W*K-bit adder/subtractor: one W-bit adder sequenced over K slices,
// LSB slice first, with the inter-slice carry held in a register.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for operands, in_ready=1
// ST_RUN  | one slice per cycle, K cycles total
// ST_DONE | result presented, out_valid=1 until out_ready
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int K = DEF_K
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W*K-1:0] op_a,
    input  logic [W*K-1:0] op_b,
    input  logic           sub,
    input  logic           cin,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W*K-1:0] sum,
    output logic           cout,
    output logic           ovf
);

    localparam int WK = W * K;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [WK-1:0]   a_sr;
    logic [WK-1:0]   b_sr;
    logic [WK-1:0]   res;
    logic [WK-1:0]   res_next;
    logic [WK-1:0]   b_in;
    logic            a_msb;
    logic            b_msb;
    logic            cout_r;
    logic            ovf_r;
    logic [W-1:0]    slice_sum;
    logic            slice_co;

    // Subtraction is A + ~B + 1; the +1 rides in on the initial carry.
    assign b_in = sub ? ~op_b : op_b;

    wide_add_seq_rca #(.N(W)) u_rca (
        .a  (a_sr[W-1:0]),
        .b  (b_sr[W-1:0]),
        .ci (carry),
        .s  (slice_sum),
        .co (slice_co)
    );

    generate
        if (K == 1) begin : g_res_one
            assign res_next = slice_sum;
        end else begin : g_res_many
            assign res_next = {slice_sum, res[WK-1:W]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sr  <= op_a;
                        b_sr  <= b_in;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        a_msb <= op_a[WK-1];
                        b_msb <= b_in[WK-1];
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res   <= res_next;
                    a_sr  <= a_sr >> W;
                    b_sr  <= b_sr >> W;
                    carry <= slice_co;
                    if (idx == IW'(K - 1)) begin
                        // Flags are frozen here so they stay put through DONE and IDLE.
                        cout_r <= slice_co;
                        ovf_r  <= (a_msb == b_msb) && (slice_sum[W-1] != a_msb);
                        state  <= ST_DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign sum       = res;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: doc/wide_add_seq.md
Name: wide_add_seq

Overview:
- Word-serial multi-precision adder/subtractor controller.
- Adds or subtracts two W*K-bit operands by sequencing one shared W-bit ripple-carry adder over K slices, least-significant slice first, with the carry registered between slices.
- Sits between an operand source and a result sink in the ALU datapath, using valid/ready handshakes on both sides.
- Trades K cycles of latency for a W-bit carry chain instead of a W*K-bit one.

Parameters:
- W, 4, slice width in bits; the width of the shared ripple-carry adder.
- K, 4, number of slices; K>=1; total operand width is W*K.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept operands (IDLE only).
- op_a  in  W*K  operand A.
- op_b  in  W*K  operand B.
- sub  in  1  1: compute A-B; 0: compute A+B+cin.
- cin  in  1  carry-in for add; ignored when sub=1.
- out_valid  out  1  result valid (DONE only).
- out_ready  in  1  sink accepts the result.
- sum  out  W*K  result.
- cout  out  1  carry out of the MSB slice. For sub this is the no-borrow flag: 1 when A>=B unsigned.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (sync, dominates all other inputs, including mid-RUN or DONE):
  - state=IDLE, slice index=0, carry reg=0.
  - sum=0, cout=0, ovf=0, out_valid=0, in_ready=1.
  - Any in-flight operation is discarded.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1:
    - capture A into a shift register.
    - capture B' into a shift register; B'=~op_b if sub else op_b.
    - carry reg <= sub ? 1 : cin.
    - idx <= 0; latch A MSB and B' MSB for the overflow check; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle the adder sees the low W bits of the A and B' shift registers plus the carry reg.
  - At the edge:
    - the slice sum enters the result register from the top, shifting it right by W.
    - both operand shift registers shift right by W.
    - carry reg <= adder carry-out; idx++.
  - When idx==K-1 at the edge, go to DONE instead of incrementing.
- Latency: exactly K RUN cycles. out_valid rises K cycles after the accepting edge. K=1 gives one RUN cycle.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable until handshake.
  - cout = final carry reg.
  - ovf = (A_msb==B'_msb) && (sum MSB != A_msb).
  - On an edge with out_ready=1: go to IDLE. Outputs keep their last values; out_valid drops.
- in_valid outside IDLE is ignored; no operand capture, no queueing.
- Throughput: K+2 cycles per operation (accept, K RUN, handshake), with the next accept one cycle after the DONE handshake.
- Arithmetic: modulo 2^(W*K); no saturation.
- Simultaneous rst with in_valid or out_ready: rst wins.

Decomposition:
- Shared include/package:
  - state encoding localparams: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - default W/K constants for the ALU build.
- One sub-module: the team's existing RippleCarryAdder instantiated with N=W as the shared slice adder.
- Controller FSM, index counter, shift registers and flag logic stay in wide_add_seq.

Test Plan (W=4, K=4):
- Add 0x1234+0x0FFF, cin=0, out_ready=1 -> sum=0x2233, cout=0, ovf=0; out_valid high exactly 4 cycles after the accept edge, for one cycle.
- Add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry propagates through all 4 slices via the carry reg).
- Sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1. Sub 0x0003-0x0005 -> sum=0xFFFE, cout=0, ovf=0.
- Add 0x7FFF+0x0001 with out_ready low 3 cycles in DONE -> sum=0x8000, ovf=1, cout=0.
  - Outputs are stable throughout the stall; in_ready=0.
  - A pulse on in_valid with different operands during the stall is ignored.
- rst asserted for one cycle during the 2nd RUN cycle -> next cycle state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0. A new op then completes correctly.
- Back-to-back: in_valid held high, out_ready=1 -> consecutive accepts 6 cycles apart; each result is correct (0x0001+0x0001=0x0002, then 0xAAAA+0x5555+cin1=0x0000 with cout=1).
